// File: rtl/regfile_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_cmd_ctrl
//
// Command sequencer between the UART receive path and the clock/pixel
// configuration register file. Incoming command bytes are buffered in a small
// FIFO, issued one at a time to the register file as a single-cycle rf_valid
// pulse, and the controller then waits for the register file's ack. Read
// responses are handed back to the UART transmit path as one byte each.
// Unsupported addresses are filtered out before issue, and an optional
// watchdog recovers from a lost ack.
//
// Parameters:
//   FIFO_DEPTH  command buffer entries (power of two, >= 2)
//   TIMEOUT     WAIT_ACK cycles before the watchdog aborts (1..255)
//
// Optional feature macro:
//   REGFILE_CMD_TIMEOUT_EN  when defined, the ack watchdog and err_timeout
//                           are built; otherwise WAIT_ACK waits forever and
//                           err_timeout is tied low.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_data, rx_valid   command byte {addr[3:0], data[3:0]} and its strobe
//   tx_data, tx_valid   response byte {addr, read value}, held until tx_ready
//   tx_ready            transmitter accepts the response byte
//   rf_address/rf_data  command address/data towards the register file
//   rf_valid            single-cycle command strobe towards the register file
//   rf_ack              register file acknowledge
//   rf_data_out(_valid) register file read data and its qualifier
//   busy                FSM not idle or commands still buffered
//   err_drop            byte lost because the FIFO was full
//   err_addr            command discarded for an unsupported address
//   err_timeout         ack not seen within TIMEOUT cycles
// ---------------------------------------------------------------------------
module regfile_cmd_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [3:0] rf_address,
    output logic [3:0] rf_data,
    output logic       rf_valid,
    input  logic       rf_ack,
    input  logic [3:0] rf_data_out,
    input  logic       rf_data_out_valid,
    output logic       busy,
    output logic       err_drop,
    output logic       err_addr,
    output logic       err_timeout
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    // Catch illegal parameter values at elaboration rather than in silicon.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("regfile_cmd_ctrl: FIFO_DEPTH must be a power of two >= 2");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("regfile_cmd_ctrl: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic         fifo_empty;
    logic         fifo_full;
    logic [7:0]   head_byte;
    logic         head_addr_ok;
    logic         push;
    logic         pop;
    logic         drop;

    logic         load_cmd;
    logic         addr_bad;
    logic         tx_load;
    logic         tx_clear;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy counter.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_byte  = fifo_mem[rd_ptr[PTR_W-1:0]];

    // Only reset (posted), baud and pixel registers exist in the register file.
    assign head_addr_ok = (head_byte[7:4] == 4'h0) ||
                          (head_byte[7:4] == 4'h1) ||
                          (head_byte[7:4] == 4'hE);

    // IDLE always drains the head, good or bad. A pop in the same cycle frees
    // a slot, so a push into a full FIFO is still accepted then.
    assign pop  = (state == IDLE) && !fifo_empty;
    assign push = rx_valid && (!fifo_full || pop);
    assign drop = rx_valid && fifo_full && !pop;

    assign rf_valid = (state == ISSUE);
    assign busy     = (state != IDLE) || !fifo_empty;

    // FIFO storage needs no reset: emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

`ifdef REGFILE_CMD_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] timeout_cnt;
    logic       timeout_hit;

    // Counter is cleared on the way into WAIT_ACK and counts every cycle spent
    // there; the abort fires on the cycle whose increment reaches TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                timeout_cnt <= '0;
            end else if (state == WAIT_ACK) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
            err_timeout <= timeout_hit;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes. An ack in WAIT_ACK wins over a
    // simultaneous timeout.
    always_comb begin
        state_next = state;
        load_cmd   = 1'b0;
        addr_bad   = 1'b0;
        tx_load    = 1'b0;
        tx_clear   = 1'b0;
`ifdef REGFILE_CMD_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_addr_ok) begin
                        load_cmd   = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        addr_bad = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (rf_address == 4'h0) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (rf_ack) begin
                    if (rf_data_out_valid) begin
                        tx_load    = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = IDLE;
                    end
                end
`ifdef REGFILE_CMD_TIMEOUT_EN
                else if (timeout_cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
`endif
            end
            RESP: begin
                if (tx_ready) begin
                    tx_clear   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The command register doubles as the register-file address/data drive,
    // so the values are already valid in the ISSUE cycle and hold until the
    // next good command is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_address <= '0;
            rf_data    <= '0;
        end else if (load_cmd) begin
            rf_address <= head_byte[7:4];
            rf_data    <= head_byte[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (tx_load) begin
            tx_data  <= {rf_address, rf_data_out};
            tx_valid <= 1'b1;
        end else if (tx_clear) begin
            tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_drop <= 1'b0;
            err_addr <= 1'b0;
        end else begin
            err_drop <= drop;
            err_addr <= addr_bad;
        end
    end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_cmd_ctrl
//
// Self-checking bench for regfile_cmd_ctrl (FIFO_DEPTH=4, TIMEOUT=15).
// Inputs change 2 time units after each rising edge; outputs are observed on
// the falling edge. Every byte expected to reach the register file is pushed
// onto exp_cmd when driven and popped when rf_valid shows up; every expected
// read response is pushed onto exp_tx and popped on the tx handshake.
// The REGFILE_CMD_TIMEOUT_EN macro selects the watchdog or no-watchdog
// expectations to match the DUT build.
// ---------------------------------------------------------------------------
module tb_regfile_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] rf_address;
    logic [3:0] rf_data;
    logic       rf_valid;
    logic       rf_ack;
    logic [3:0] rf_data_out;
    logic       rf_data_out_valid;
    logic       busy;
    logic       err_drop;
    logic       err_addr;
    logic       err_timeout;

    int errors = 0;
    int checks = 0;
    int drop_cnt = 0;
    int addr_cnt = 0;
    int to_cnt = 0;
    int rf_pulses = 0;

    logic [7:0] exp_cmd [$];
    logic [7:0] exp_tx [$];

    regfile_cmd_ctrl #(
        .FIFO_DEPTH(4),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rf_address(rf_address),
        .rf_data(rf_data),
        .rf_valid(rf_valid),
        .rf_ack(rf_ack),
        .rf_data_out(rf_data_out),
        .rf_data_out_valid(rf_data_out_valid),
        .busy(busy),
        .err_drop(err_drop),
        .err_addr(err_addr),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Single point of comparison for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drives one command byte for one cycle; the scoreboard learns about it
    // now if it is expected to be issued to the register file.
    task automatic applyStimulus(input logic [7:0] b, input bit expIssue);
        rx_valid = 1'b1;
        rx_data  = b;
        if (expIssue) begin
            exp_cmd.push_back(b);
        end
        step();
        rx_valid = 1'b0;
    endtask

    // Waits (bounded) for the next rf_valid and acknowledges it one cycle later.
    task automatic serviceOne();
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (rf_valid) found = 1'b1;
        end
        checkOutput("issue_seen", 32'(found), 32'd1);
        if (found) begin
            step();
            rf_ack = 1'b1;
            step();
            rf_ack = 1'b0;
        end
    endtask

    // Register-file and transmitter side monitor: scoreboard pops and error
    // pulse counting.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_valid) begin
                rf_pulses++;
                if (exp_cmd.size() == 0) begin
                    checkOutput("rf_unexpected", 32'(rf_valid), 32'd0);
                end else begin
                    checkOutput("rf_cmd", 32'({rf_address, rf_data}), 32'(exp_cmd.pop_front()));
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    checkOutput("tx_unexpected", 32'(tx_valid), 32'd0);
                end else begin
                    checkOutput("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                end
            end
            if (err_drop) drop_cnt++;
            if (err_addr) addr_cnt++;
            if (err_timeout) to_cnt++;
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int drop0;
        int pulses0;

        rst_n             = 1'b0;
        rx_data           = '0;
        rx_valid          = 1'b0;
        tx_ready          = 1'b0;
        rf_ack            = 1'b0;
        rf_data_out       = '0;
        rf_data_out_valid = 1'b0;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        checkOutput("reset_outs", 32'({tx_data, tx_valid, rf_address, rf_data, rf_valid,
                                       busy, err_drop, err_addr, err_timeout}), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Write 0x13: rf_valid in cycle 2, ack in cycle 3, idle in cycle 4
        $display("[TB] write 0x13");
        applyStimulus(8'h13, 1'b1);
        @(negedge clk);
        checkOutput("wr_busy_c1", 32'(busy), 32'd1);
        step();
        @(negedge clk);
        checkOutput("wr_valid_c2", 32'({rf_valid, rf_address, rf_data}), 32'({1'b1, 4'h1, 4'h3}));
        step();
        rf_ack = 1'b1;
        @(negedge clk);
        checkOutput("wr_valid_c3", 32'(rf_valid), 32'd0);
        step();
        rf_ack = 1'b0;
        @(negedge clk);
        checkOutput("wr_idle_c4", 32'({busy, tx_valid}), 32'd0);
        step();

        // Read 0xEF, register file returns 9, transmitter stalls 5 cycles
        $display("[TB] read 0xEF");
        applyStimulus(8'hEF, 1'b1);
        step();
        step();
        rf_ack            = 1'b1;
        rf_data_out_valid = 1'b1;
        rf_data_out       = 4'h9;
        exp_tx.push_back(8'hE9);
        step();
        rf_ack            = 1'b0;
        rf_data_out_valid = 1'b0;
        rf_data_out       = 4'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rd_hold", 32'({tx_valid, tx_data}), 32'({1'b1, 8'hE9}));
            step();
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        @(negedge clk);
        checkOutput("rd_released", 32'({tx_valid, busy}), 32'd0);
        step();

        // Posted 0x00 then 0x12: pulses in cycles 2 and 4, no ack on the first
        $display("[TB] posted then write");
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h12, 1'b1);
        @(negedge clk);
        checkOutput("post_valid_c2", 32'({rf_valid, rf_address}), 32'({1'b1, 4'h0}));
        step();
        @(negedge clk);
        checkOutput("post_gap_c3", 32'(rf_valid), 32'd0);
        step();
        @(negedge clk);
        checkOutput("post_next_c4", 32'({rf_valid, rf_address, rf_data}), 32'({1'b1, 4'h1, 4'h2}));
        step();
        rf_ack = 1'b1;
        step();
        rf_ack = 1'b0;
        @(negedge clk);
        checkOutput("post_idle", 32'(busy), 32'd0);
        step();

        // Bad address 0x55: err_addr pulse, nothing issued
        $display("[TB] bad address");
        applyStimulus(8'h55, 1'b0);
        step();
        @(negedge clk);
        checkOutput("bad_err_c2", 32'({err_addr, rf_valid}), 32'({1'b1, 1'b0}));
        step();
        @(negedge clk);
        checkOutput("bad_err_c3", 32'({err_addr, rf_valid, busy}), 32'd0);
        step();
        checkOutput("bad_err_count", 32'(addr_cnt), 32'd1);

        // Overflow: six bytes while stalled in RESP, four kept, two dropped
        $display("[TB] overflow while in RESP");
        applyStimulus(8'hEF, 1'b1);
        step();
        step();
        rf_ack            = 1'b1;
        rf_data_out_valid = 1'b1;
        rf_data_out       = 4'h5;
        exp_tx.push_back(8'hE5);
        step();
        rf_ack            = 1'b0;
        rf_data_out_valid = 1'b0;
        drop0 = drop_cnt;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h12, 1'b1);
        applyStimulus(8'h13, 1'b1);
        applyStimulus(8'h14, 1'b1);
        applyStimulus(8'h1A, 1'b0);
        applyStimulus(8'h1B, 1'b0);
        @(negedge clk);
        checkOutput("ovf_drop_last", 32'({err_drop, tx_valid, busy}), 32'({1'b1, 1'b1, 1'b1}));
        step();
        checkOutput("ovf_drop_count", 32'(drop_cnt - drop0), 32'd2);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serviceOne();
        end
        step();
        @(negedge clk);
        checkOutput("ovf_drained", 32'({busy, 8'(exp_cmd.size())}), 32'd0);
        step();

        // A handful of randomized acknowledged writes
        $display("[TB] random writes");
        for (int i = 0; i < 6; i++) begin
            b[7:4] = ($urandom_range(0, 1) == 0) ? 4'h1 : 4'hE;
            b[3:0] = 4'($urandom_range(0, 14));
            applyStimulus(b, 1'b1);
            serviceOne();
        end
        step();

        // Lost ack on 0x14 with 0x12 queued behind it
        $display("[TB] lost ack");
        applyStimulus(8'h14, 1'b1);
        applyStimulus(8'h12, 1'b1);
        @(negedge clk);
        checkOutput("lost_issue_c2", 32'({rf_valid, rf_address, rf_data}), 32'({1'b1, 4'h1, 4'h4}));
        repeat (15) step();
        @(negedge clk);
        checkOutput("lost_c17", 32'({err_timeout, busy}), 32'({1'b0, 1'b1}));
`ifdef REGFILE_CMD_TIMEOUT_EN
        step();
        @(negedge clk);
        checkOutput("lost_timeout_c18", 32'(err_timeout), 32'd1);
        step();
        @(negedge clk);
        checkOutput("lost_next_c19", 32'({rf_valid, rf_address, rf_data}), 32'({1'b1, 4'h1, 4'h2}));
        step();
        rf_ack = 1'b1;
        step();
        rf_ack = 1'b0;
        checkOutput("lost_timeout_count", 32'(to_cnt), 32'd1);
        step();
`else
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            checkOutput("lost_stuck", 32'({rf_valid, err_timeout, busy}), 32'({1'b0, 1'b0, 1'b1}));
        end
        step();
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("lost_reset", 32'({busy, rf_valid}), 32'd0);
        exp_cmd.delete();
        step();
        rst_n = 1'b1;
        step();
`endif

        // Reset while in WAIT_ACK with two bytes queued
        $display("[TB] reset mid-operation");
        applyStimulus(8'h14, 1'b1);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h1E, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_reset_outs", 32'({tx_data, tx_valid, rf_address, rf_data, rf_valid,
                                           busy, err_drop, err_addr, err_timeout}), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        pulses0 = rf_pulses;
        repeat (10) step();
        checkOutput("mid_reset_no_issue", 32'(rf_pulses - pulses0), 32'd0);
        @(negedge clk);
        checkOutput("mid_reset_idle", 32'(busy), 32'd0);
        step();

        checkOutput("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        checkOutput("tx_queue_empty", 32'(exp_tx.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
